// File: rtl/axi4_wide_to_axi4_long_rd.sv
// Wide-to-narrow AXI4 read adapter: one wide burst of len+1 beats becomes one narrow
// burst of 4*(len+1) beats, and the narrow beats are packed back into wide words.
module axi4_wide_to_axi4_long_rd #(
   parameter int unsigned IDSIZE = 1,
   parameter int unsigned ASIZE  = 12,
   parameter int unsigned LSIZE  = 12,
   parameter int unsigned WDSIZE = 128,
   parameter int unsigned NDSIZE = 32
) (
   input  logic                axi_aclk,
   input  logic                axi_aresetn,
   // upstream read address
   input  logic [IDSIZE-1:0]   s_arid,
   input  logic [ASIZE-1:0]    s_araddr,
   input  logic [LSIZE-1:0]    s_arlen,
   input  logic                s_arvalid,
   output logic                s_arready,
   // upstream wide read data
   output logic [IDSIZE-1:0]   s_rid,
   output logic [WDSIZE-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                s_rvalid,
   input  logic                s_rready,
   // downstream read address
   output logic [IDSIZE-1:0]   n_arid,
   output logic [ASIZE-1:0]    n_araddr,
   output logic [LSIZE+1:0]    n_arlen,
   output logic                n_arvalid,
   input  logic                n_arready,
   // downstream narrow read data
   input  logic [IDSIZE-1:0]   n_rid,
   input  logic [NDSIZE-1:0]   n_rdata,
   input  logic [1:0]          n_rresp,
   input  logic                n_rlast,
   input  logic                n_rvalid,
   output logic                n_rready
);

   localparam int unsigned RATIO = WDSIZE / NDSIZE;
   localparam int unsigned LANEW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [LANEW-1:0] LAST_LANE = LANEW'(RATIO - 1);
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

   state_e             state_q, state_d;
   logic [IDSIZE-1:0]  id_q, id_d;
   logic [ASIZE-1:0]   addr_q, addr_d;
   logic [LSIZE-1:0]   len_q, len_d;
   logic [LANEW-1:0]   lane_q, lane_d;
   logic [LSIZE-1:0]   beat_q, beat_d;
   logic [WDSIZE-1:0]  wbuf_q, wbuf_d;
   logic [1:0]         resp_q, resp_d;
   logic               done_q, done_d;
   logic               s_arready_q, s_arready_d;
   logic               n_arvalid_q, n_arvalid_d;
   logic               s_rvalid_q, s_rvalid_d;
   logic [WDSIZE-1:0]  s_rdata_q, s_rdata_d;
   logic [1:0]         s_rresp_q, s_rresp_d;
   logic               s_rlast_q, s_rlast_d;

   logic               nr_hs_c, sr_hs_c, final_beat_c, last_lane_c;
   logic [WDSIZE-1:0]  word_c;
   logic [1:0]         resp_max_c;
   logic               unused_rid;

   assign unused_rid   = ^n_rid;
   assign n_rready     = (state_q == DATA) & ~done_q & (~s_rvalid_q | s_rready);
   assign nr_hs_c      = n_rvalid & n_rready;
   assign sr_hs_c      = s_rvalid_q & s_rready;
   assign final_beat_c = (beat_q == len_q);
   assign last_lane_c  = (lane_q == LAST_LANE);
   assign resp_max_c   = (n_rresp > resp_q) ? n_rresp : resp_q;

   // Lanes above the current one are already zero because wbuf is cleared per word.
   always_comb begin
      word_c = wbuf_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (lane_q == LANEW'(i)) word_c[i*NDSIZE +: NDSIZE] = n_rdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      lane_d     = lane_q;
      beat_d     = beat_q;
      wbuf_d     = wbuf_q;
      resp_d     = resp_q;
      done_d     = done_q;
      s_rvalid_d = s_rvalid_q;
      s_rdata_d  = s_rdata_q;
      s_rresp_d  = s_rresp_q;
      s_rlast_d  = s_rlast_q;

      case (state_q)
         IDLE: begin
            if (s_arvalid && s_arready_q) begin
               id_d    = s_arid;
               addr_d  = s_araddr;
               len_d   = s_arlen;
               lane_d  = '0;
               beat_d  = '0;
               wbuf_d  = '0;
               resp_d  = '0;
               done_d  = 1'b0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (n_arvalid_q && n_arready) state_d = DATA;
         end
         DATA: begin
            if (sr_hs_c && s_rlast_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (sr_hs_c) begin
         s_rvalid_d = 1'b0;
         s_rlast_d  = 1'b0;
      end

      // A word completes on its last lane or early on n_rlast (truncated burst).
      if (nr_hs_c) begin
         if (last_lane_c || n_rlast) begin
            s_rvalid_d = 1'b1;
            s_rdata_d  = word_c;
            wbuf_d     = '0;
            lane_d     = '0;
            resp_d     = '0;
            beat_d     = beat_q + LSIZE'(1);
            if (final_beat_c && last_lane_c) begin
               s_rlast_d = 1'b1;
               done_d    = 1'b1;
               s_rresp_d = n_rlast ? resp_max_c : RESP_SLVERR;
            end else if (n_rlast) begin
               s_rlast_d = 1'b1;
               done_d    = 1'b1;
               s_rresp_d = RESP_SLVERR;
            end else begin
               s_rlast_d = 1'b0;
               s_rresp_d = resp_max_c;
            end
         end else begin
            wbuf_d = word_c;
            lane_d = lane_q + LANEW'(1);
            resp_d = resp_max_c;
         end
      end

      s_arready_d = (state_d == IDLE);
      n_arvalid_d = (state_d == ADDR);
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state_q     <= IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         lane_q      <= '0;
         beat_q      <= '0;
         wbuf_q      <= '0;
         resp_q      <= '0;
         done_q      <= 1'b0;
         s_arready_q <= 1'b0;
         n_arvalid_q <= 1'b0;
         s_rvalid_q  <= 1'b0;
         s_rdata_q   <= '0;
         s_rresp_q   <= '0;
         s_rlast_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         lane_q      <= lane_d;
         beat_q      <= beat_d;
         wbuf_q      <= wbuf_d;
         resp_q      <= resp_d;
         done_q      <= done_d;
         s_arready_q <= s_arready_d;
         n_arvalid_q <= n_arvalid_d;
         s_rvalid_q  <= s_rvalid_d;
         s_rdata_q   <= s_rdata_d;
         s_rresp_q   <= s_rresp_d;
         s_rlast_q   <= s_rlast_d;
      end
   end

   assign s_arready = s_arready_q;
   assign n_arvalid = n_arvalid_q;
   assign n_arid    = id_q;
   assign n_araddr  = addr_q;
   assign n_arlen   = {len_q, 2'b11};
   assign s_rid     = id_q;
   assign s_rdata   = s_rdata_q;
   assign s_rresp   = s_rresp_q;
   assign s_rlast   = s_rlast_q;
   assign s_rvalid  = s_rvalid_q;

endmodule

// File: tb/tb_axi4_wide_to_axi4_long_rd.sv
// Bench for axi4_wide_to_axi4_long_rd: table of bursts driven by random handshakes,
// wide beats compared against a packing model built from the narrow stream.
module tb_axi4_wide_to_axi4_long_rd;

   localparam int unsigned IDW = 1;
   localparam int unsigned AW  = 12;
   localparam int unsigned LW  = 12;
   localparam int unsigned WW  = 128;
   localparam int unsigned NW  = 32;

   logic          clk = 1'b0;
   logic          axi_aresetn;
   logic [IDW-1:0] s_arid;
   logic [AW-1:0] s_araddr;
   logic [LW-1:0] s_arlen;
   logic          s_arvalid, s_arready;
   logic [IDW-1:0] s_rid;
   logic [WW-1:0] s_rdata;
   logic [1:0]    s_rresp;
   logic          s_rlast, s_rvalid, s_rready;
   logic [IDW-1:0] n_arid;
   logic [AW-1:0] n_araddr;
   logic [LW+1:0] n_arlen;
   logic          n_arvalid, n_arready;
   logic [IDW-1:0] n_rid;
   logic [NW-1:0] n_rdata;
   logic [1:0]    n_rresp;
   logic          n_rlast, n_rvalid, n_rready;

   always #5 clk = ~clk;

   axi4_wide_to_axi4_long_rd dut (
      .axi_aclk(clk), .axi_aresetn(axi_aresetn),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .n_arid(n_arid), .n_araddr(n_araddr), .n_arlen(n_arlen),
      .n_arvalid(n_arvalid), .n_arready(n_arready),
      .n_rid(n_rid), .n_rdata(n_rdata), .n_rresp(n_rresp), .n_rlast(n_rlast),
      .n_rvalid(n_rvalid), .n_rready(n_rready)
   );

   typedef struct {
      logic [NW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } narrow_t;

   typedef struct {
      logic [WW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } wide_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      int             len;
      int             base;
      int             err_at;
      int             trunc_at;
      bit             drop_last;
      bit             rnd_resp;
      int             p_nv;
      int             p_sr;
      bit             stall;
      int             abort_n;
      bit             chk_d0;
      logic [WW-1:0]  exp_d0;
      int             exp_arlen;
      int             exp_nbeats;
   } vec_t;

   narrow_t stream_q[$];
   wide_t   exp_q[$];
   vec_t    tbl[13];
   int      total_n = 0;
   int      bad_n   = 0;

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic bit rnd(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   function automatic vec_t vdef();
      vec_t v;
      v.id = '0; v.addr = '0; v.len = 0; v.base = int'($urandom);
      v.err_at = -1; v.trunc_at = -1; v.drop_last = 0; v.rnd_resp = 0;
      v.p_nv = 100; v.p_sr = 100; v.stall = 0; v.abort_n = -1;
      v.chk_d0 = 0; v.exp_d0 = '0; v.exp_arlen = 3; v.exp_nbeats = 1;
      return v;
   endfunction

   // Pack the narrow stream 4 beats per wide word, lane 0 first, and apply the
   // error/last rules for early or missing n_rlast.
   task automatic build_model(input int len);
      int total;
      int i;
      total = 4 * (len + 1);
      i = 0;
      exp_q.delete();
      for (int w = 0; w <= len && i < stream_q.size(); w++) begin
         wide_t e;
         bit    stop;
         e.data = '0;
         e.resp = 2'b00;
         e.last = 1'b0;
         stop = 0;
         for (int k = 0; k < 4 && i < stream_q.size(); k++) begin
            e.data[32*k +: 32] = stream_q[i].data;
            if (stream_q[i].resp > e.resp) e.resp = stream_q[i].resp;
            i++;
            if (stream_q[i-1].last) begin
               stop = 1;
               break;
            end
         end
         if (stop && i != total) begin
            e.last = 1'b1;
            e.resp = 2'b10;
            exp_q.push_back(e);
            break;
         end
         if (w == len) begin
            e.last = 1'b1;
            if (!stop) e.resp = 2'b10;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_idle();
      s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
      n_arready = 1'b0; n_rvalid = 1'b0; n_rlast = 1'b0;
      n_rdata = '0; n_rresp = '0; n_rid = '0; s_rready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_arready"}, WW'(s_arready), WW'(0));
      chk({tag, "_rvalid"},  WW'(s_rvalid),  WW'(0));
      chk({tag, "_rlast"},   WW'(s_rlast),   WW'(0));
      chk({tag, "_rresp"},   WW'(s_rresp),   WW'(0));
      chk({tag, "_rdata"},   s_rdata,        WW'(0));
      chk({tag, "_rid"},     WW'(s_rid),     WW'(0));
      chk({tag, "_narvalid"}, WW'(n_arvalid), WW'(0));
      chk({tag, "_nrready"}, WW'(n_rready),  WW'(0));
   endtask

   task automatic run_burst(input int row, input vec_t v);
      int total_nb, nb, idx, got, cyc, budget, stall_cnt;
      bit ar_done, nar_done, hs_n, fin;
      logic [WW-1:0] held;
      string tag;
      tag = $sformatf("r%0d", row);
      total_nb = 4 * (v.len + 1);
      nb = (v.trunc_at >= 0) ? v.trunc_at + 1 : total_nb;
      idx = 0; got = 0; cyc = 0; stall_cnt = 0;
      ar_done = 0; nar_done = 0; fin = 0; held = '0;
      budget = 40 * total_nb + 200;
      stream_q.delete();
      for (int i = 0; i < nb; i++) begin
         narrow_t b;
         b.data = 32'(v.base + i);
         b.resp = (i == v.err_at) ? 2'b10 : (v.rnd_resp ? 2'($urandom_range(0, 1)) : 2'b00);
         b.last = (i == nb - 1) && !v.drop_last;
         stream_q.push_back(b);
      end
      build_model(v.len);

      s_arid = v.id; s_araddr = v.addr; s_arlen = LW'(v.len); s_arvalid = 1'b1;
      n_arready = rnd(v.p_nv);
      s_rready = v.stall ? 1'b0 : rnd(v.p_sr);
      while (!fin && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (s_arvalid && s_arready) ar_done = 1;
         if (n_arvalid && n_arready && !nar_done) begin
            nar_done = 1;
            chk({tag, "_narlen"},  WW'(n_arlen),  WW'(v.exp_arlen));
            chk({tag, "_naraddr"}, WW'(n_araddr), WW'(v.addr));
            chk({tag, "_narid"},   WW'(n_arid),   WW'(v.id));
         end
         hs_n = n_rvalid && n_rready;
         if (hs_n) idx++;
         if (v.stall && s_rvalid && stall_cnt < 20) begin
            if (stall_cnt == 0) held = s_rdata;
            else chk({tag, "_stall_data"}, s_rdata, held);
            chk({tag, "_stall_nrready"}, WW'(n_rready), WW'(0));
            stall_cnt++;
         end
         if (s_rvalid && s_rready) begin
            if (got < exp_q.size()) begin
               chk($sformatf("%s_b%0d_data", tag, got), s_rdata, exp_q[got].data);
               chk($sformatf("%s_b%0d_resp", tag, got), WW'(s_rresp), WW'(exp_q[got].resp));
               chk($sformatf("%s_b%0d_last", tag, got), WW'(s_rlast), WW'(exp_q[got].last));
               chk($sformatf("%s_b%0d_rid", tag, got), WW'(s_rid), WW'(v.id));
               if (got == 0 && v.chk_d0) chk({tag, "_d0_const"}, s_rdata, v.exp_d0);
            end else begin
               total_n++;
               bad_n++;
               $display("FAIL %s_extra_beat act=%0d exp<%0d", tag, got, exp_q.size());
            end
            if (s_rlast) fin = 1;
            got++;
         end
         if (v.abort_n >= 0 && idx >= v.abort_n) fin = 1;
         if (!fin) begin
            @(posedge clk);
            #1;
            if (ar_done) s_arvalid = 1'b0;
            n_arready = rnd(v.p_nv);
            if (!(n_rvalid && !hs_n)) begin
               if (idx < nb && rnd(v.p_nv)) begin
                  n_rvalid = 1'b1;
                  n_rdata  = stream_q[idx].data;
                  n_rresp  = stream_q[idx].resp;
                  n_rlast  = stream_q[idx].last;
                  n_rid    = IDW'($urandom);
               end else begin
                  n_rvalid = 1'b0;
               end
            end
            s_rready = (v.stall && stall_cnt < 20) ? 1'b0 : rnd(v.p_sr);
         end
      end

      if (!fin) begin
         total_n++;
         bad_n++;
         $display("FAIL %s_timeout act=%0d beats exp=%0d", tag, got, v.exp_nbeats);
      end
      @(posedge clk);
      #1;
      if (v.abort_n >= 0) begin
         axi_aresetn = 1'b0;
         drive_idle();
         @(posedge clk);
         @(negedge clk);
         check_reset_outputs({tag, "_abort"});
         axi_aresetn = 1'b1;
         @(negedge clk);
         chk({tag, "_abort_arready"}, WW'(s_arready), WW'(1));
      end else begin
         drive_idle();
         chk({tag, "_nbeats"}, WW'(got), WW'(v.exp_nbeats));
         @(negedge clk);
         chk({tag, "_arready_after"}, WW'(s_arready), WW'(1));
      end
   endtask

   initial begin
      axi_aresetn = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      axi_aresetn = 1'b1;
      @(negedge clk);
      chk("rst_arready_after", WW'(s_arready), WW'(1));

      // zero-length burst with the known 1,2,3,4 pattern
      tbl[0] = vdef(); tbl[0].addr = 12'h010; tbl[0].base = 1;
      tbl[0].chk_d0 = 1; tbl[0].exp_d0 = 128'h00000004_00000003_00000002_00000001;
      // error response on narrow beat 2 only
      tbl[1] = vdef(); tbl[1].addr = 12'h100; tbl[1].len = 1; tbl[1].err_at = 2;
      tbl[1].exp_arlen = 7; tbl[1].exp_nbeats = 2;
      // early n_rlast on narrow beat 5
      tbl[2] = vdef(); tbl[2].len = 1; tbl[2].trunc_at = 5;
      tbl[2].exp_arlen = 7; tbl[2].exp_nbeats = 2;
      // n_rlast missing on the final beat
      tbl[3] = vdef(); tbl[3].len = 2; tbl[3].drop_last = 1;
      tbl[3].exp_arlen = 11; tbl[3].exp_nbeats = 3;
      // long burst, random handshakes both sides
      tbl[4] = vdef(); tbl[4].id = 1'b1; tbl[4].addr = 12'h005; tbl[4].len = 249; tbl[4].base = 0;
      tbl[4].p_nv = 50; tbl[4].p_sr = 50; tbl[4].exp_arlen = 999; tbl[4].exp_nbeats = 250;
      // upstream stall with a word ready
      tbl[5] = vdef(); tbl[5].len = 3; tbl[5].stall = 1;
      tbl[5].exp_arlen = 15; tbl[5].exp_nbeats = 4;
      // reset mid-data, then a fresh burst
      tbl[6] = vdef(); tbl[6].id = 1'b1; tbl[6].addr = 12'h3c0; tbl[6].len = 3; tbl[6].abort_n = 6;
      tbl[6].exp_arlen = 15;
      tbl[7] = vdef(); tbl[7].addr = 12'h040; tbl[7].len = 2; tbl[7].rnd_resp = 1;
      tbl[7].p_nv = 70; tbl[7].p_sr = 60; tbl[7].exp_arlen = 11; tbl[7].exp_nbeats = 3;
      // maximum length burst
      tbl[8] = vdef(); tbl[8].id = 1'b1; tbl[8].addr = 12'hfff; tbl[8].len = 4095;
      tbl[8].exp_arlen = 16383; tbl[8].exp_nbeats = 4096;
      // early n_rlast exactly on lane 3 of a non-final word, and on the very first beat
      tbl[9] = vdef(); tbl[9].len = 2; tbl[9].trunc_at = 3;
      tbl[9].exp_arlen = 11; tbl[9].exp_nbeats = 1;
      tbl[10] = vdef(); tbl[10].len = 0; tbl[10].trunc_at = 0;
      tbl[10].exp_arlen = 3; tbl[10].exp_nbeats = 1;
      for (int r = 11; r < 13; r++) begin
         tbl[r] = vdef();
         tbl[r].id = IDW'($urandom);
         tbl[r].addr = AW'($urandom);
         tbl[r].len = int'($urandom_range(0, 30));
         tbl[r].rnd_resp = 1;
         tbl[r].p_nv = int'($urandom_range(30, 100));
         tbl[r].p_sr = int'($urandom_range(30, 100));
         tbl[r].exp_arlen = tbl[r].len * 4 + 3;
         tbl[r].exp_nbeats = tbl[r].len + 1;
      end

      for (int r = 0; r < 13; r++) run_burst(r, tbl[r]);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/axi4_wide_to_axi4_long_rd.md
AXI4_WIDE_TO_AXI4_LONG_RD -- requirements
Module: axi4_wide_to_axi4_long_rd

Interface
REQ-001 Parameter IDSIZE, 1, AXI ID width.
REQ-002 Parameter ASIZE, 12, address width.
REQ-003 Parameter LSIZE, 12, upstream arlen width; downstream arlen width is LSIZE+2.
REQ-004 Parameter WDSIZE, 128, upstream (wide) data width.
REQ-005 Parameter NDSIZE, 32, downstream (narrow) data width; RATIO = WDSIZE/NDSIZE = 4.
REQ-006 axi_aclk  in  1  the single clock; all logic is clocked on its rising edge.
REQ-007 axi_aresetn  in  1  synchronous, active-low reset.
REQ-008 s_arid/s_araddr/s_arlen/s_arvalid  in  IDSIZE/ASIZE/LSIZE/1  upstream read request.
REQ-009 s_arready  out  1  upstream AR ready.
REQ-010 s_rid/s_rdata/s_rresp/s_rlast/s_rvalid  out  IDSIZE/WDSIZE/2/1/1  upstream wide read data.
REQ-011 s_rready  in  1  upstream R ready.
REQ-012 n_arid/n_araddr/n_arlen/n_arvalid  out  IDSIZE/ASIZE/LSIZE+2/1  downstream read request.
REQ-013 n_arready  in  1  downstream AR ready.
REQ-014 n_rid/n_rdata/n_rresp/n_rlast/n_rvalid  in  IDSIZE/NDSIZE/2/1/1  downstream narrow read data.
REQ-015 n_rready  out  1  downstream R ready.

Function
REQ-016 One burst is in flight at a time; FSM states IDLE, ADDR, DATA.
REQ-017 IDLE: s_arready=1; s_arvalid&s_arready latches id, addr, len and moves to ADDR next cycle.
REQ-018 ADDR: n_arvalid=1 with n_arid=latched id, n_araddr=latched addr unchanged, n_arlen=(len+1)*4-1 computed at LSIZE+2 bits with no overflow; n_arvalid holds until n_arready, then DATA.
REQ-019 DATA: a 2-bit lane counter and an LSIZE-bit wide-beat counter track progress; s_arready=0 in ADDR and DATA.
REQ-020 Narrow beat k of a wide word (k=0..3) lands in s_rdata[NDSIZE*k +: NDSIZE]; beat 0 is the least significant lane.
REQ-021 n_rready = (state==DATA) & (!s_rvalid | s_rready); a narrow beat completing a word may be accepted in the cycle the previous wide word drains.
REQ-022 s_rvalid asserts the cycle after the 4th narrow handshake of a word and holds, data stable, until s_rready.
REQ-023 s_rid = latched burst id; n_rid is ignored.
REQ-024 s_rresp = numerically largest n_rresp among the word's 4 beats.
REQ-025 s_rlast = 1 on wide beat number len (0-based), driven by the wide-beat counter, not by n_rlast.
REQ-026 n_rlast before the final narrow beat: remaining lanes zero-filled, word emitted with s_rlast=1 and s_rresp=2'b10; remaining expected beats are not waited for.
REQ-027 n_rlast absent on the final narrow beat: word emitted normally except s_rresp=2'b10.
REQ-028 After the s_rlast handshake the FSM returns to IDLE; s_arready=1 in the following cycle.
REQ-029 Zero-length burst (s_arlen=0) issues n_arlen=3 and returns exactly one wide beat with s_rlast=1.
REQ-030 Maximum burst (s_arlen=2^LSIZE-1) issues n_arlen=2^(LSIZE+2)-1; counters do not wrap before the final beat.

Reset
REQ-031 With axi_aresetn=0 at a clock edge: state=IDLE; counters, latched id/addr/len and lane register cleared.
REQ-032 Output values during and after reset: s_arready=0 while reset asserted, 1 in first cycle after; s_rvalid=0, s_rlast=0, s_rresp=0, s_rdata=0, s_rid=0, n_arvalid=0, n_rready=0.
REQ-033 Reset mid-burst aborts the burst; no partial word is emitted; no outstanding downstream beats are tracked after reset.

Verification
REQ-034 s_arlen=0, addr=0x010, n_rdata 1,2,3,4, n_rlast on 4 -> n_arlen=3, one beat s_rdata=0x00000004_00000003_00000002_00000001, s_rlast=1, s_rresp=0.
REQ-035 id=1, s_arlen=249, addr=5, n_rvalid 50% random, s_rready 50% random -> n_arlen=999, 250 wide beats, s_rid=1, s_rlast only on beat 249, data = incrementing narrow pattern packed in order.
REQ-036 s_arlen=1, n_rresp=2'b10 on narrow beat 2 only -> beat 0 s_rresp=2'b10, beat 1 s_rresp=0.
REQ-037 s_arlen=1, n_rlast on narrow beat 5 -> beat 1 lanes 2,3 zero, s_rlast=1, s_rresp=2'b10, FSM back to IDLE.
REQ-038 s_rready held low 20 cycles with word ready -> n_rready=0 throughout, s_rdata stable, no narrow beat lost.
REQ-039 axi_aresetn low for 1 cycle mid-DATA -> all outputs at reset values next cycle, then new request accepted and completed correctly.
